// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_pkg
// Brief   : Phase encoding, lamp patterns and phase-length helper shared by
//           the traffic light controller and its lamp decoder.
// Revision: 1.0
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    LEFT        = 3'd0,
    GREEN       = 3'd1,
    YELLOW      = 3'd2,
    CLEAR       = 3'd3,
    PREEMPT     = 3'd4,
    PREEMPT_YEL = 3'd5
  } phase_t;

  localparam logic [3:0] LAMP_LEFT   = 4'b1001;
  localparam logic [3:0] LAMP_GREEN  = 4'b0100;
  localparam logic [3:0] LAMP_YELLOW = 4'b0010;
  localparam logic [3:0] LAMP_RED    = 4'b0001;

  // Length of a counted phase; PREEMPT is timed separately and reports 1.
  function automatic int phase_dur(input phase_t ph, input int left_cyc,
                                   input int green_cyc, input int yellow_cyc,
                                   input int clear_cyc);
    case (ph)
      LEFT:        return left_cyc;
      GREEN:       return green_cyc;
      YELLOW:      return yellow_cyc;
      CLEAR:       return clear_cyc;
      PREEMPT_YEL: return yellow_cyc;
      default:     return 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_lamp_decode.sv
`default_nettype none
// ============================================================================
// Module  : traffic_lamp_decode
// Brief   : Maps the controller phase and per-approach ownership to lamps.
// Revision: 1.0
// ============================================================================
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  phase_t     phase,
  input  logic       is_active,
  output logic [3:0] lamp
);

  always_comb begin
    lamp = LAMP_RED;
    if (is_active) begin
      case (phase)
        LEFT:        lamp = LAMP_LEFT;
        GREEN:       lamp = LAMP_GREEN;
        YELLOW:      lamp = LAMP_YELLOW;
        PREEMPT_YEL: lamp = LAMP_YELLOW;
        default:     lamp = LAMP_RED;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : traffic_light_ctrl
// Brief   : Round-robin N-approach intersection controller with emergency
//           preemption; TRAFFIC_PREEMPT_YELLOW_EN adds a yellow lead-in.
// Revision: 1.0
// ============================================================================
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR      = 2,
  parameter int LEFT_CYC    = 5,
  parameter int GREEN_CYC   = 10,
  parameter int YELLOW_CYC  = 3,
  parameter int CLEAR_CYC   = 1,
  parameter int PREEMPT_MIN = 1,
  parameter int CNT_W       = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      emergency,
  output logic [4*N_APPR-1:0]       lamps,
  output logic [$clog2(N_APPR)-1:0] active,
  output logic [2:0]                phase,
  output logic                      preempted
);

  localparam int AW      = $clog2(N_APPR);
  localparam int PCW     = (PREEMPT_MIN > 1) ? $clog2(PREEMPT_MIN) : 1;
  localparam int MAX_DUR = (LEFT_CYC > GREEN_CYC ? LEFT_CYC : GREEN_CYC) >
                           (YELLOW_CYC > CLEAR_CYC ? YELLOW_CYC : CLEAR_CYC) ?
                           (LEFT_CYC > GREEN_CYC ? LEFT_CYC : GREEN_CYC) :
                           (YELLOW_CYC > CLEAR_CYC ? YELLOW_CYC : CLEAR_CYC);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PREEMPT_MIN - 1);
  localparam logic [AW-1:0]  LAST_APPR = AW'(N_APPR - 1);

  if ((MAX_DUR - 1) > ((1 << CNT_W) - 1)) begin : g_cnt_w_check
    $error("traffic_light_ctrl: CNT_W too narrow for the longest phase");
  end
  if (N_APPR < 2) begin : g_appr_check
    $error("traffic_light_ctrl: N_APPR must be at least 2");
  end

  phase_t           r_phase;
  logic [AW-1:0]    r_active;
  logic [CNT_W-1:0] r_cnt;
  phase_t           r_saved_phase;
  logic [CNT_W-1:0] r_saved_cnt;
  logic [AW-1:0]    r_saved_active;
  logic [PCW-1:0]   r_pcnt;

  int               w_cur_dur;
  logic             w_last;
  phase_t           w_nxt_phase;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [AW-1:0]    w_nxt_active;

  // Successor state of normal sequencing; also what preemption saves.
  always_comb begin
    w_cur_dur    = phase_dur(r_phase, LEFT_CYC, GREEN_CYC, YELLOW_CYC, CLEAR_CYC);
    w_last       = (r_cnt == CNT_W'(w_cur_dur - 1));
    w_nxt_phase  = r_phase;
    w_nxt_cnt    = r_cnt + CNT_W'(1);
    w_nxt_active = r_active;
    if (w_last) begin
      w_nxt_cnt = '0;
      case (r_phase)
        LEFT:   w_nxt_phase = GREEN;
        GREEN:  w_nxt_phase = YELLOW;
        YELLOW: w_nxt_phase = CLEAR;
        CLEAR: begin
          w_nxt_phase  = LEFT;
          w_nxt_active = (r_active == LAST_APPR) ? '0 : r_active + AW'(1);
        end
        default: w_nxt_phase = r_phase;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase        <= LEFT;
      r_active       <= '0;
      r_cnt          <= '0;
      r_pcnt         <= '0;
      r_saved_phase  <= LEFT;
      r_saved_cnt    <= '0;
      r_saved_active <= '0;
    end else begin
      case (r_phase)
        PREEMPT: begin
          if (r_pcnt != PCNT_LAST) begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
          if (!emergency && (r_pcnt == PCNT_LAST)) begin
            r_phase  <= r_saved_phase;
            r_cnt    <= r_saved_cnt;
            r_active <= r_saved_active;
          end
        end
`ifdef TRAFFIC_PREEMPT_YELLOW_EN
        PREEMPT_YEL: begin
          if (w_last) begin
            r_phase <= PREEMPT;
            r_pcnt  <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          if (emergency) begin
            r_saved_phase  <= w_nxt_phase;
            r_saved_cnt    <= w_nxt_cnt;
            r_saved_active <= w_nxt_active;
`ifdef TRAFFIC_PREEMPT_YELLOW_EN
            if ((r_phase == LEFT) || (r_phase == GREEN)) begin
              r_phase <= PREEMPT_YEL;
              r_cnt   <= '0;
            end else begin
              r_phase <= PREEMPT;
              r_pcnt  <= '0;
            end
`else
            r_phase <= PREEMPT;
            r_pcnt  <= '0;
`endif
          end else begin
            r_phase  <= w_nxt_phase;
            r_cnt    <= w_nxt_cnt;
            r_active <= w_nxt_active;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_APPR; i++) begin : g_lamp
    traffic_lamp_decode u_dec (
      .phase     (r_phase),
      .is_active (r_active == AW'(i)),
      .lamp      (lamps[4*i+3:4*i])
    );
  end

  assign active    = r_active;
  assign phase     = r_phase;
  assign preempted = (r_phase == PREEMPT) || (r_phase == PREEMPT_YEL);

endmodule
`default_nettype wire
